// File: rtl/mem_init_loader.sv
// mem_init_loader: debug-side filler for the 4-byte-lane data memory.
// Accepts a valid/ready stream of 32-bit words and packs them in pairs into
// the memory's dual-slot debug write (Datain1 -> A, Datain2 -> A+4). An odd
// tail word goes out as a single-slot write.
// Optional read-back checksum pass: define MEM_LOADER_VERIFY_EN.
module mem_init_loader #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 11
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              s_valid,
   input  logic [31:0]       s_data,
   output logic              s_ready,
   output logic [31:0]       mem_address,
   output logic [31:0]       mem_Datain1,
   output logic [31:0]       mem_Datain2,
   output logic [3:0]        mem_Wr,
   output logic              mem_enable_debug,
   input  logic [31:0]       mem_Dataout,
   output logic              busy,
   output logic              done,
`ifdef MEM_LOADER_VERIFY_EN
   output logic              mismatch,
`endif
   output logic              error
);

`ifdef MEM_LOADER_VERIFY_EN
   typedef enum logic [2:0] {IDLE, CHECK, GET0, GET1, WR_PAIR, WR_SINGLE, FINISH, VERIFY} state_t;
`else
   typedef enum logic [2:0] {IDLE, CHECK, GET0, GET1, WR_PAIR, WR_SINGLE, FINISH} state_t;
`endif

   // Wide enough to hold base + 4*count without wrapping.
   localparam int SUM_W = ADDR_W + CNT_W + 3;

   state_t            state_reg;
   logic [ADDR_W-1:0] ptr_reg;
   logic [CNT_W-1:0]  remaining_reg;
   logic [31:0]       hold0_reg;

   logic [SUM_W-1:0]  end_addr;
   logic              overflow;
   logic              transfer;

   // End of the requested region, checked against the memory size in CHECK
   assign end_addr = SUM_W'(ptr_reg) + (SUM_W'(remaining_reg) << 2);
   assign overflow = end_addr > (SUM_W'(1) << ADDR_W);
   assign transfer = s_valid && s_ready;

   // Address outputs follow the pointer; bits above ADDR_W are tied low
   assign mem_address = {{(32-ADDR_W){1'b0}}, ptr_reg};

`ifdef MEM_LOADER_VERIFY_EN
   logic [ADDR_W-1:0] base_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  vcnt_reg;
   logic [31:0]       chk_wr_reg;
   logic [31:0]       chk_rd_reg;
   logic [31:0]       chk_rd_next;

   // Rotate-left-1 then XOR, folded over each read-back word
   assign chk_rd_next = {chk_rd_reg[30:0], chk_rd_reg[31]} ^ mem_Dataout;
`else
   logic unused_dataout;
   assign unused_dataout = ^mem_Dataout;
`endif

   // Loader FSM; every output is a register set on entry to the state that owns it
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg        <= IDLE;
         ptr_reg          <= '0;
         remaining_reg    <= '0;
         hold0_reg        <= '0;
         s_ready          <= 1'b0;
         mem_Datain1      <= '0;
         mem_Datain2      <= '0;
         mem_Wr           <= '0;
         mem_enable_debug <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
         base_reg         <= '0;
         count_reg        <= '0;
         vcnt_reg         <= '0;
         chk_wr_reg       <= '0;
         chk_rd_reg       <= '0;
         mismatch         <= 1'b0;
`endif
      end else begin
         done             <= 1'b0;
         mem_Wr           <= 4'h0;
         mem_enable_debug <= 1'b0;
         case (state_reg)
            IDLE: begin
               s_ready <= 1'b0;
               if (start) begin
                  ptr_reg       <= base_addr;
                  remaining_reg <= word_count;
                  error         <= 1'b0;
                  busy          <= 1'b1;
                  state_reg     <= CHECK;
`ifdef MEM_LOADER_VERIFY_EN
                  base_reg      <= base_addr;
                  count_reg     <= word_count;
                  chk_wr_reg    <= '0;
                  chk_rd_reg    <= '0;
                  mismatch      <= 1'b0;
`endif
               end
            end
            CHECK: begin
               if (ptr_reg[1:0] != 2'b00 || overflow) begin
                  error     <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= FINISH;
               end else if (remaining_reg == '0) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= FINISH;
               end else begin
                  s_ready   <= 1'b1;
                  state_reg <= GET0;
               end
            end
            GET0: begin
               if (transfer) begin
                  hold0_reg <= s_data;
`ifdef MEM_LOADER_VERIFY_EN
                  chk_wr_reg <= {chk_wr_reg[30:0], chk_wr_reg[31]} ^ s_data;
`endif
                  if (remaining_reg == CNT_W'(1)) begin
                     // Odd tail: single-slot write with the second slot off
                     s_ready     <= 1'b0;
                     mem_Wr      <= 4'hF;
                     mem_Datain1 <= s_data;
                     mem_Datain2 <= '0;
                     state_reg   <= WR_SINGLE;
                  end else begin
                     state_reg   <= GET1;
                  end
               end
            end
            GET1: begin
               if (transfer) begin
`ifdef MEM_LOADER_VERIFY_EN
                  chk_wr_reg <= {chk_wr_reg[30:0], chk_wr_reg[31]} ^ s_data;
`endif
                  s_ready          <= 1'b0;
                  mem_Wr           <= 4'hF;
                  mem_enable_debug <= 1'b1;
                  mem_Datain1      <= hold0_reg;
                  mem_Datain2      <= s_data;
                  state_reg        <= WR_PAIR;
               end
            end
            WR_PAIR: begin
               ptr_reg       <= ptr_reg + ADDR_W'(8);
               remaining_reg <= remaining_reg - CNT_W'(2);
               if (remaining_reg == CNT_W'(2)) begin
`ifdef MEM_LOADER_VERIFY_EN
                  ptr_reg   <= base_reg;
                  vcnt_reg  <= '0;
                  state_reg <= VERIFY;
`else
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= FINISH;
`endif
               end else begin
                  s_ready   <= 1'b1;
                  state_reg <= GET0;
               end
            end
            WR_SINGLE: begin
               ptr_reg       <= ptr_reg + ADDR_W'(4);
               remaining_reg <= '0;
`ifdef MEM_LOADER_VERIFY_EN
               ptr_reg       <= base_reg;
               vcnt_reg      <= '0;
               state_reg     <= VERIFY;
`else
               done          <= 1'b1;
               busy          <= 1'b0;
               state_reg     <= FINISH;
`endif
            end
`ifdef MEM_LOADER_VERIFY_EN
            VERIFY: begin
               // Read address k issued in cycle k, its data folded in cycle k+1
               vcnt_reg <= vcnt_reg + CNT_W'(1);
               if (vcnt_reg < count_reg)
                  ptr_reg <= ptr_reg + ADDR_W'(4);
               if (vcnt_reg != '0)
                  chk_rd_reg <= chk_rd_next;
               if (vcnt_reg == count_reg) begin
                  if (chk_rd_next != chk_wr_reg) begin
                     error    <= 1'b1;
                     mismatch <= 1'b1;
                  end
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= FINISH;
               end
            end
`endif
            FINISH: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_init_loader.sv
// Directed bench for mem_init_loader: pairing, odd tail, stalls, error
// paths, zero-length load and mid-load reset.
module tb_mem_init_loader;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [10:0] word_count = '0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic [31:0] mem_address;
   logic [31:0] mem_Datain1;
   logic [31:0] mem_Datain2;
   logic [3:0]  mem_Wr;
   logic        mem_enable_debug;
   logic [31:0] mem_Dataout = '0;
   logic        busy;
   logic        done;
   logic        error;
`ifdef MEM_LOADER_VERIFY_EN
   logic        mismatch;
`endif

   mem_init_loader #(.ADDR_W(12), .CNT_W(11)) dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .start            (start),
      .base_addr        (base_addr),
      .word_count       (word_count),
      .s_valid          (s_valid),
      .s_data           (s_data),
      .s_ready          (s_ready),
      .mem_address      (mem_address),
      .mem_Datain1      (mem_Datain1),
      .mem_Datain2      (mem_Datain2),
      .mem_Wr           (mem_Wr),
      .mem_enable_debug (mem_enable_debug),
      .mem_Dataout      (mem_Dataout),
      .busy             (busy),
      .done             (done),
`ifdef MEM_LOADER_VERIFY_EN
      .mismatch         (mismatch),
`endif
      .error            (error)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [3:0]  wr;
      logic        en;
   } wr_t;

   wr_t wq[$];
   int  checks = 0;
   int  errors = 0;
   int  done_cnt = 0;
   int  rdy_cnt = 0;
   int  rdy_in_wr = 0;

   // Record write cycles, done pulses and s_ready cycles on the falling edge
   always @(negedge Clk) begin
      if (!Reset) begin
         if (mem_Wr != 4'h0) begin
            wq.push_back('{mem_address, mem_Datain1, mem_Datain2, mem_Wr, mem_enable_debug});
            $display("write addr=%h d1=%h d2=%h wr=%h en=%0d",
                     mem_address, mem_Datain1, mem_Datain2, mem_Wr, mem_enable_debug);
         end
         if (done) done_cnt++;
         if (s_ready) rdy_cnt++;
         if (s_ready && mem_Wr != 4'h0) rdy_in_wr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the start edge (CHECK)
   task automatic start_load(input logic [11:0] b, input logic [10:0] n);
      wq.delete();
      done_cnt   = 0;
      rdy_cnt    = 0;
      base_addr  = b;
      word_count = n;
      start      = 1'b1;
      @(negedge Clk);
      start      = 1'b0;
   endtask

   task automatic send(input logic [31:0] w);
      int got;
      got     = 0;
      s_valid = 1'b1;
      s_data  = w;
      for (int i = 0; i < 50; i++) begin
         if (s_ready) begin
            got = 1;
            @(negedge Clk);
            break;
         end
         @(negedge Clk);
      end
      s_valid = 1'b0;
      chk("send_accept", got, 1);
   endtask

   task automatic wait_done();
      int got;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            got = 1;
            break;
         end
         @(negedge Clk);
      end
      chk("done_seen", got, 1);
      @(negedge Clk);
   endtask

   task automatic check_wr(input int idx, input logic [31:0] a, input logic [31:0] d1,
                           input logic [31:0] d2, input logic en);
      if (wq.size() > idx) begin
         chk("wr_addr", wq[idx].a, a);
         chk("wr_d1", wq[idx].d1, d1);
         chk("wr_d2", wq[idx].d2, d2);
         chk("wr_we", 32'(wq[idx].wr), 32'hF);
         chk("wr_en", 32'(wq[idx].en), 32'(en));
      end else begin
         chk("wr_present", wq.size(), idx + 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge Clk);
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_d1", mem_Datain1, 0);
      chk("rst_d2", mem_Datain2, 0);
      chk("rst_wr", 32'(mem_Wr), 0);
      chk("rst_en", 32'(mem_enable_debug), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      Reset = 1'b0;
      @(negedge Clk);

      // Four words at 0x100 -> two paired writes
      $display("load base=100 count=4");
      start_load(12'h100, 11'd4);
      chk("t1_busy", 32'(busy), 1);
      send(32'h11111111);
      send(32'h22222222);
      send(32'h33333333);
      send(32'h44444444);
      wait_done();
      chk("t1_nwr", wq.size(), 2);
      check_wr(0, 32'h100, 32'h11111111, 32'h22222222, 1'b1);
      check_wr(1, 32'h108, 32'h33333333, 32'h44444444, 1'b1);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_low", 32'(done), 0);
      chk("t1_error", 32'(error), 0);
      chk("t1_busy_end", 32'(busy), 0);

      // Three words at 0 -> pair then single tail
      $display("load base=000 count=3");
      start_load(12'h000, 11'd3);
      send(32'hA0A0A0A0);
      send(32'hB1B1B1B1);
      send(32'hC2C2C2C2);
      wait_done();
      chk("t2_nwr", wq.size(), 2);
      check_wr(0, 32'h000, 32'hA0A0A0A0, 32'hB1B1B1B1, 1'b1);
      check_wr(1, 32'h008, 32'hC2C2C2C2, 32'h0, 1'b0);

      // Five-cycle stall between words, with an ignored start in the gap
      $display("load base=200 count=2 with stall");
      start_load(12'h200, 11'd2);
      send(32'hDEADBEEF);
      repeat (2) @(negedge Clk);
      base_addr  = 12'h7F0;
      word_count = 11'd1;
      start      = 1'b1;
      @(negedge Clk);
      start      = 1'b0;
      repeat (2) @(negedge Clk);
      chk("t3_no_early_wr", wq.size(), 0);
      chk("t3_busy", 32'(busy), 1);
      send(32'hCAFEF00D);
      wait_done();
      chk("t3_nwr", wq.size(), 1);
      check_wr(0, 32'h200, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
      chk("t3_done_cnt", done_cnt, 1);

      // Misaligned base
      $display("load base=102 count=2 (misaligned)");
      start_load(12'h102, 11'd2);
      wait_done();
      chk("t4_err", 32'(error), 1);
      chk("t4_nwr", wq.size(), 0);
      chk("t4_ready", rdy_cnt, 0);
      chk("t4_done_cnt", done_cnt, 1);
      repeat (3) @(negedge Clk);
      chk("t4_err_sticky", 32'(error), 1);

      // Overflow past the 4 KB space
      $display("load base=ff8 count=4 (overflow)");
      start_load(12'hFF8, 11'd4);
      chk("t4b_err_cleared", 32'(error), 0);
      wait_done();
      chk("t4b_err", 32'(error), 1);
      chk("t4b_nwr", wq.size(), 0);

      // Exactly fills the top of memory: legal, pointer wraps to 0
      $display("load base=ff8 count=2 (top fit)");
      start_load(12'hFF8, 11'd2);
      send(32'h01234567);
      send(32'h89ABCDEF);
      wait_done();
      chk("t4c_err", 32'(error), 0);
      chk("t4c_nwr", wq.size(), 1);
      check_wr(0, 32'hFF8, 32'h01234567, 32'h89ABCDEF, 1'b1);
      chk("t4c_addr_wrap", mem_address, 0);

      // Zero-length load: done two cycles after start
      $display("load base=000 count=0");
      start_load(12'h000, 11'd0);
      chk("t5_done_early", 32'(done), 0);
      chk("t5_busy", 32'(busy), 1);
      @(negedge Clk);
      chk("t5_done", 32'(done), 1);
      chk("t5_busy_end", 32'(busy), 0);
      @(negedge Clk);
      chk("t5_done_pulse", 32'(done), 0);
      chk("t5_ready", rdy_cnt, 0);
      chk("t5_nwr", wq.size(), 0);

      // Reset while waiting for the second word of a pair
      $display("load base=300 count=4, reset in GET1");
      start_load(12'h300, 11'd4);
      send(32'h55555555);
      chk("t6_in_get1", 32'(s_ready), 1);
      Reset = 1'b1;
      #1;
      chk("t6_rst_ready", 32'(s_ready), 0);
      chk("t6_rst_addr", mem_address, 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_d1", mem_Datain1, 0);
      chk("t6_rst_d2", mem_Datain2, 0);
      chk("t6_rst_error", 32'(error), 0);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      $display("load base=040 count=2 after reset");
      start_load(12'h040, 11'd2);
      send(32'h76543210);
      send(32'hFEDCBA98);
      wait_done();
      chk("t6_nwr", wq.size(), 1);
      check_wr(0, 32'h040, 32'h76543210, 32'hFEDCBA98, 1'b1);
      chk("t6_error", 32'(error), 0);

      chk("ready_in_write", rdy_in_wr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_init_loader.md
Name: mem_init_loader

Overview:
- Debug-side writer for the 4-byte-lane data memory. It fills the memory before the core leaves debug.
- Accepts a valid/ready stream of 32-bit words and packs them into pairs.
- Drives the memory's dual-slot debug write: Datain1 goes to word address A, Datain2 to A+4, in one cycle.
- Sits between the debug/host link and the data memory; owns the memory's address, data, Wr and enable_debug inputs while busy.

Parameters:
- ADDR_W, 12, byte-address bits used by the memory (4 KB space).
- CNT_W, 11, width of the word-count field (maximum 1024 words).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a load. Sampled only in IDLE.
- base_addr  in  ADDR_W  byte start address; bits [1:0] must be 00.
- word_count  in  CNT_W  number of 32-bit words to load; 0 is legal.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word.
- s_ready  out  1  loader accepts s_data this cycle.
- mem_address  out  32  memory address; bits [31:ADDR_W] are always 0.
- mem_Datain1  out  32  first-slot write data.
- mem_Datain2  out  32  second-slot write data.
- mem_Wr  out  4  byte write enables.
- mem_enable_debug  out  1  selects the memory's dual-slot debug write.
- mem_Dataout  in  32  memory read data; used only with the optional feature.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  sticky until the next start: bad alignment, or address overflow.

Behaviour:
- Reset values: all outputs 0, state IDLE.
- Transfer rule: a stream transfer happens only when s_valid and s_ready are both 1.
- IDLE:
  - s_ready=0.
  - On start:
    - Latch base_addr into the address pointer, and word_count into the remaining counter.
    - Clear error; set busy.
  - Next state is CHECK.
- CHECK (1 cycle), checks in this priority order:
  - base_addr[1:0]!=0: set error, go to FINISH.
  - base_addr + 4*word_count > 2^ADDR_W: set error, go to FINISH.
  - word_count==0: go to FINISH.
  - Otherwise go to GET0.
- GET0:
  - s_ready=1; on transfer, capture the word into hold0.
  - If remaining==1, go to WR_SINGLE; otherwise go to GET1.
- GET1:
  - s_ready=1; on transfer, capture the word into hold1, then go to WR_PAIR.
- WR_PAIR (1 cycle):
  - mem_enable_debug=1, mem_Wr=4'hF, mem_address=ptr.
  - Datain1=hold0, Datain2=hold1.
  - Then ptr+=8, remaining-=2.
  - If remaining becomes 0, go to FINISH; otherwise go to GET0.
- WR_SINGLE (1 cycle), used for the odd tail word:
  - mem_enable_debug=0 (second slot disabled), mem_Wr=4'hF, mem_address=ptr.
  - Datain1=hold0, Datain2=0.
  - Then ptr+=4, remaining=0, go to FINISH.
- Output values outside write cycles:
  - mem_Wr=0 and mem_enable_debug=0 in every state except WR_PAIR and WR_SINGLE.
  - mem_address holds ptr; data outputs hold their last values.
- FINISH (1 cycle): done=1, busy=0, then go to IDLE.
- Throughput: 2 words per 3 cycles at full stream rate. s_ready is never asserted in write cycles.
- start while busy is ignored.
- Reset mid-load:
  - All outputs go to 0 immediately and the state returns to IDLE.
  - A partially written memory is not rolled back.
- mem_Dataout is ignored unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_LOADER_VERIFY_EN.
- When defined, a VERIFY pass replaces the direct FINISH after the last write:
  - ptr reloads to base_addr; mem_Wr=0, mem_enable_debug=0.
  - Each word is read with 1-cycle latency (synchronous SRAM) and compared with the expected value.
  - Expected values come from a running XOR/rotate checksum over the loaded stream.
  - The checksum is compared against the same checksum of the read-back words. It is computed by rotate-left-1 then XOR with each word.
  - On mismatch, set error. Done still pulses.
  - Adds word_count+1 cycles.
- Extra output mismatch (1): checksum-fail flag only.
- When not defined:
  - No VERIFY state, no mismatch port.
  - mem_Dataout stays an unused input.

Test Plan:
- base_addr=0x100, word_count=4, words 0x11111111..0x44444444 → two WR_PAIR cycles:
  - (0x100, 0x11111111, 0x22222222), then (0x108, 0x33333333, 0x44444444).
  - done pulses once; error=0.
- word_count=3 at base 0x000 → one WR_PAIR at 0x000, then WR_SINGLE at 0x008 with enable_debug=0, Datain1=word2.
- Stream stalls: s_valid low for 5 cycles between word0 and word1 → no write issued until word1 is accepted; data is correct.
- base_addr=0x102 → error=1, zero write cycles, done pulses. Also base_addr=0xFF8 with word_count=4 → error=1 (overflow).
- word_count=0 → done pulses 2 cycles after start; no s_ready; no writes.
- Reset asserted during GET1 → all outputs 0 immediately; a new start loads normally. With MEM_LOADER_VERIFY_EN, a corrupted mem_Dataout word gives mismatch=1 and error=1.
